rvfi_trace_player: RTL and testbench

Synthesizable RVFI *producer* that replays a loaded table of retirement records onto a single-channel (NRET=1) RVFI bus. It stands in for a core wrapper so `rvfi_insn_check` and the other checkers can be exercised with known-good and deliberately-corrupted traces, without elaborating a full CPU. It sits where a core wrapper would: its RVFI outputs feed checker RVFI inputs directly.

---
 rtl/rvfi_trace_pkg.sv | 43 ++++
 rtl/rvfi_trace_table.sv | 29 ++
 rtl/rvfi_trace_player.sv | 141 ++++++++++++++
 tb/tb_rvfi_trace_player.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rvfi_trace_pkg.sv
// Shared types for the RVFI trace player.
//   rvfi_rec_t : one retirement record (every RVFI field except valid/order)
//   state_t    : playback FSM state
//   sanitise() : field fix-ups applied as a record retires
package rvfi_trace_pkg;

  localparam int XLEN_P = 32;
  localparam int ILEN_P = 32;
  localparam int MASK_W = XLEN_P / 8;

  typedef struct packed {
    logic [ILEN_P-1:0] insn;
    logic              trap;
    logic              halt;
    logic              intr;
    logic [4:0]        rs1_addr;
    logic [4:0]        rs2_addr;
    logic [4:0]        rd_addr;
    logic [XLEN_P-1:0] rs1_rdata;
    logic [XLEN_P-1:0] rs2_rdata;
    logic [XLEN_P-1:0] rd_wdata;
    logic [XLEN_P-1:0] pc_rdata;
    logic [XLEN_P-1:0] pc_wdata;
    logic [XLEN_P-1:0] mem_addr;
    logic [XLEN_P-1:0] mem_rdata;
    logic [XLEN_P-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_rmask;
    logic [MASK_W-1:0] mem_wmask;
  } rvfi_rec_t;

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  // Only the x0 write data and the final halt are touched; everything else,
  // legal or not, is replayed verbatim so corrupted traces reach the checkers.
  function automatic rvfi_rec_t sanitise(input rvfi_rec_t r, input logic last);
    rvfi_rec_t s;
    s = r;
    if (r.rd_addr == 5'd0) s.rd_wdata = '0;
    if (last) s.halt = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/rvfi_trace_table.sv
// Trace record storage: DEPTH x rvfi_rec_t register file, not reset.
//   clock : write clock
//   we    : write enable
//   waddr : write slot
//   wdata : record to store
//   raddr : read slot (asynchronous read)
//   rdata : record at raddr
module rvfi_trace_table
  import rvfi_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  rvfi_rec_t                wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output rvfi_rec_t                rdata
);

  rvfi_rec_t mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rvfi_trace_player.sv
// Replays a preloaded table of retirement records onto a single-channel
// RVFI bus, standing in for a core wrapper in front of RVFI checkers.
//   clock, resetn          : clock, synchronous active-low reset
//   load_valid/idx/rec     : table write port, honoured only in IDLE
//   length, start          : records to play (clamped to DEPTH), go
//   bubble                 : retire nothing this PLAY cycle
//   done                   : playback finished (state DONE)
//   rvfi_*                 : registered RVFI outputs
//
// state | meaning
// IDLE  | table writable, waiting for start
// PLAY  | one record retired per non-bubble cycle
// DONE  | playback complete, held until reset
module rvfi_trace_player
  import rvfi_trace_pkg::*;
#(
  parameter int XLEN  = XLEN_P,
  parameter int ILEN  = ILEN_P,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     load_valid,
  input  logic [$clog2(DEPTH)-1:0] load_idx,
  input  rvfi_rec_t                load_rec,
  input  logic [$clog2(DEPTH):0]   length,
  input  logic                     start,
  input  logic                     bubble,
  output logic                     done,
  output logic                     rvfi_valid,
  output logic [63:0]              rvfi_order,
  output logic [ILEN-1:0]          rvfi_insn,
  output logic                     rvfi_trap,
  output logic                     rvfi_halt,
  output logic                     rvfi_intr,
  output logic [4:0]               rvfi_rs1_addr,
  output logic [4:0]               rvfi_rs2_addr,
  output logic [4:0]               rvfi_rd_addr,
  output logic [XLEN-1:0]          rvfi_rs1_rdata,
  output logic [XLEN-1:0]          rvfi_rs2_rdata,
  output logic [XLEN-1:0]          rvfi_rd_wdata,
  output logic [XLEN-1:0]          rvfi_pc_rdata,
  output logic [XLEN-1:0]          rvfi_pc_wdata,
  output logic [XLEN-1:0]          rvfi_mem_addr,
  output logic [XLEN-1:0]          rvfi_mem_rdata,
  output logic [XLEN-1:0]          rvfi_mem_wdata,
  output logic [XLEN/8-1:0]        rvfi_mem_rmask,
  output logic [XLEN/8-1:0]        rvfi_mem_wmask
);

  localparam int IW = $clog2(DEPTH);
  localparam int LW = IW + 1;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q;
  logic [63:0]    order_q;
  logic [63:0]    order_out_q;
  logic [LW-1:0]  len_q;
  logic [LW-1:0]  len_clamped;
  logic           valid_q;
  logic           retire;
  logic           last;
  logic           we;
  rvfi_rec_t      rec_q;
  rvfi_rec_t      rd_rec;

  assign we = load_valid && (state_q == IDLE);

  rvfi_trace_table #(.DEPTH(DEPTH)) u_table (
    .clock (clock),
    .we    (we),
    .waddr (load_idx),
    .wdata (load_rec),
    .raddr (idx_q),
    .rdata (rd_rec)
  );

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    len_clamped = (length > LW'(DEPTH)) ? LW'(DEPTH) : length;
    // len_q is at least 1 whenever PLAY is reached, so len_q-1 never underflows there.
    last        = ({1'b0, idx_q} == (len_q - LW'(1)));
    case (state_q)
      IDLE: if (start) state_d = (length == '0) ? DONE : PLAY;
      PLAY: begin
        if (!bubble) begin
          retire = 1'b1;
          if (last) state_d = DONE;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      order_q     <= '0;
      order_out_q <= '0;
      len_q       <= '0;
      valid_q     <= 1'b0;
      rec_q       <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= 1'b0;
      if (state_q == IDLE && start) len_q <= len_clamped;
      if (retire) begin
        valid_q     <= 1'b1;
        rec_q       <= sanitise(rd_rec, last);
        order_out_q <= order_q;
        order_q     <= order_q + 64'd1;
        idx_q       <= idx_q + IW'(1);
      end
    end
  end

  assign done           = (state_q == DONE);
  assign rvfi_valid     = valid_q;
  assign rvfi_order     = order_out_q;
  assign rvfi_insn      = rec_q.insn;
  assign rvfi_trap      = rec_q.trap;
  assign rvfi_halt      = rec_q.halt;
  assign rvfi_intr      = rec_q.intr;
  assign rvfi_rs1_addr  = rec_q.rs1_addr;
  assign rvfi_rs2_addr  = rec_q.rs2_addr;
  assign rvfi_rd_addr   = rec_q.rd_addr;
  assign rvfi_rs1_rdata = rec_q.rs1_rdata;
  assign rvfi_rs2_rdata = rec_q.rs2_rdata;
  assign rvfi_rd_wdata  = rec_q.rd_wdata;
  assign rvfi_pc_rdata  = rec_q.pc_rdata;
  assign rvfi_pc_wdata  = rec_q.pc_wdata;
  assign rvfi_mem_addr  = rec_q.mem_addr;
  assign rvfi_mem_rdata = rec_q.mem_rdata;
  assign rvfi_mem_wdata = rec_q.mem_wdata;
  assign rvfi_mem_rmask = rec_q.mem_rmask;
  assign rvfi_mem_wmask = rec_q.mem_wmask;

endmodule

// File: tb/tb_rvfi_trace_player.sv
module tb_rvfi_trace_player;
  import rvfi_trace_pkg::*;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        load_valid = 1'b0;
  logic [3:0]  load_idx = '0;
  rvfi_rec_t   load_rec = '0;
  logic [4:0]  length = '0;
  logic        start = 1'b0;
  logic        bubble = 1'b0;
  logic        done, rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_insn;
  logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
  logic [31:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata;
  logic [31:0] rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
  logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;

  int n_cmp = 0;
  int n_bad = 0;

  rvfi_trace_player #(.XLEN(32), .ILEN(32), .DEPTH(16)) dut (
    .clock(clock), .resetn(resetn),
    .load_valid(load_valid), .load_idx(load_idx), .load_rec(load_rec),
    .length(length), .start(start), .bubble(bubble), .done(done),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
    .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
    .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rd_addr(rvfi_rd_addr),
    .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
    .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst_n;
    logic        start;
    logic [4:0]  len;
    logic        bubble;
    logic        exp_valid;
    logic [63:0] exp_order;
    logic [31:0] exp_insn;
    logic [31:0] exp_wd;
    logic        exp_halt;
    logic        exp_done;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic rvfi_rec_t mk_rec(input logic [31:0] insn, input logic [4:0] rd,
                                       input logic [31:0] wd);
    rvfi_rec_t r;
    r = '0;
    r.insn      = insn;
    r.rd_addr   = rd;
    r.rd_wdata  = wd;
    r.rs1_addr  = rd + 5'd1;
    r.pc_rdata  = insn ^ 32'h5555_0000;
    r.pc_wdata  = insn ^ 32'h5555_0004;
    r.mem_rmask = 4'hF;
    return r;
  endfunction

  task automatic load(input logic [3:0] idx, input rvfi_rec_t r);
    load_valid = 1'b1;
    load_idx   = idx;
    load_rec   = r;
    step();
    load_valid = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    start  = 1'b0;
    bubble = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_insn3 [3];
    logic [63:0] last_order;
    logic [31:0] last_insn;
    logic        last_halt;
    int          cnt;

    exp_insn3[0] = 32'h0010_0093;
    exp_insn3[1] = 32'h0000_0013;
    exp_insn3[2] = 32'h0020_8133;

    //             rst  st  len    bub  valid order   insn          rd_wdata      halt done
    vecs[0]  = '{1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 64'd0, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 5'd3, 1'b0, 1'b1, 64'd0, 32'h0010_0093, 32'h1,       1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 64'd1, 32'h0000_0013, 32'h0,       1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 5'd3, 1'b0, 1'b1, 64'd2, 32'h0020_8133, 32'h2,       1'b1, 1'b1};
    vecs[4]  = '{1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 64'd2, 32'h0020_8133, 32'h2,       1'b1, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 64'd2, 32'h0020_8133, 32'h2,       1'b1, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 64'd0, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 64'd0, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 5'd2, 1'b1, 1'b0, 64'd0, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 5'd2, 1'b0, 1'b1, 64'd0, 32'h0010_0093, 32'h1,       1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 5'd2, 1'b0, 1'b1, 64'd1, 32'h0000_0013, 32'h0,       1'b1, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 5'd2, 1'b1, 1'b0, 64'd1, 32'h0000_0013, 32'h0,       1'b1, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 64'd0, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 64'd0, 32'h0,        32'h0,        1'b0, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 64'd0, 32'h0,        32'h0,        1'b0, 1'b1};

    // Reset values
    resetn = 1'b0;
    repeat (3) step();
    check("rst valid", 64'(rvfi_valid), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst order", rvfi_order, 64'd0);
    check("rst state", 64'(dut.state_q), 64'(IDLE));
    check("rst all outputs", 64'(|{rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr, rvfi_rs1_addr,
          rvfi_rs2_addr, rvfi_rd_addr, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata,
          rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata,
          rvfi_mem_rmask, rvfi_mem_wmask}), 64'd0);
    resetn = 1'b1;

    load(4'd0, mk_rec(32'h0010_0093, 5'd1, 32'h1));
    load(4'd1, mk_rec(32'h0000_0013, 5'd0, 32'hDEAD_BEEF));
    load(4'd2, mk_rec(32'h0020_8133, 5'd2, 32'h2));
    load(4'd3, mk_rec(32'h0031_0193, 5'd3, 32'h10));
    for (int i = 4; i < 16; i++)
      load(4'(i), mk_rec(32'h1000_0000 + 32'(i), 5'(i), 32'(i)));

    // Table-driven vectors: basic playback, x0 sanitising, bubbles, length 0
    for (int i = 0; i < NVEC; i++) begin
      resetn = vecs[i].rst_n;
      start  = vecs[i].start;
      length = vecs[i].len;
      bubble = vecs[i].bubble;
      step();
      check($sformatf("v%0d valid", i), 64'(rvfi_valid), 64'(vecs[i].exp_valid));
      check($sformatf("v%0d order", i), rvfi_order, vecs[i].exp_order);
      check($sformatf("v%0d insn", i), 64'(rvfi_insn), 64'(vecs[i].exp_insn));
      check($sformatf("v%0d rd_wdata", i), 64'(rvfi_rd_wdata), 64'(vecs[i].exp_wd));
      check($sformatf("v%0d halt", i), 64'(rvfi_halt), 64'(vecs[i].exp_halt));
      check($sformatf("v%0d done", i), 64'(done), 64'(vecs[i].exp_done));
    end
    resetn = 1'b1;
    start  = 1'b0;
    bubble = 1'b0;

    // Loads during PLAY and DONE must not reach the table
    do_reset();
    start = 1'b1; length = 5'd3;
    step();
    start = 1'b0;
    load_valid = 1'b1; load_idx = 4'd0; load_rec = mk_rec(32'hFFFF_FFFF, 5'd7, 32'h7);
    repeat (4) step();
    load_valid = 1'b0;
    check("guard load done", 64'(done), 64'd1);
    do_reset();
    start = 1'b1; length = 5'd1;
    step();
    start = 1'b0;
    step();
    check("guard replay insn", 64'(rvfi_insn), 64'h0010_0093);
    check("guard replay halt", 64'(rvfi_halt), 64'd1);
    check("guard replay done", 64'(done), 64'd1);

    // Reset during the second retirement
    do_reset();
    start = 1'b1; length = 5'd3;
    step();
    start = 1'b0;
    step();
    check("midrst first valid", 64'(rvfi_valid), 64'd1);
    resetn = 1'b0;
    step();
    check("midrst valid", 64'(rvfi_valid), 64'd0);
    check("midrst order", rvfi_order, 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst state", 64'(dut.state_q), 64'(IDLE));
    resetn = 1'b1;
    start = 1'b1; length = 5'd3;
    step();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("replay%0d valid", k), 64'(rvfi_valid), 64'd1);
      check($sformatf("replay%0d order", k), rvfi_order, 64'(k));
      check($sformatf("replay%0d insn", k), 64'(rvfi_insn), 64'(exp_insn3[k]));
    end
    check("replay done", 64'(done), 64'd1);

    // Length above DEPTH clamps to 16 records
    do_reset();
    start = 1'b1; length = 5'd20;
    step();
    start = 1'b0;
    cnt = 0; last_order = '1; last_insn = '0; last_halt = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (rvfi_valid) begin
        cnt++;
        last_order = rvfi_order;
        last_insn  = rvfi_insn;
        last_halt  = rvfi_halt;
      end
      if (done) break;
    end
    check("clamp count", 64'(cnt), 64'd16);
    check("clamp done", 64'(done), 64'd1);
    check("clamp last order", last_order, 64'd15);
    check("clamp last insn", 64'(last_insn), 64'h1000_000F);
    check("clamp last halt", 64'(last_halt), 64'd1);

    // Load and start in the same IDLE cycle: new data is played
    do_reset();
    load_valid = 1'b1; load_idx = 4'd0; load_rec = mk_rec(32'hCAFE_0013, 5'd5, 32'h55);
    start = 1'b1; length = 5'd1;
    step();
    load_valid = 1'b0; start = 1'b0;
    step();
    check("ldstart valid", 64'(rvfi_valid), 64'd1);
    check("ldstart insn", 64'(rvfi_insn), 64'hCAFE_0013);
    check("ldstart rd_wdata", 64'(rvfi_rd_wdata), 64'h55);
    check("ldstart order", rvfi_order, 64'd0);
    check("ldstart halt", 64'(rvfi_halt), 64'd1);
    check("ldstart done", 64'(done), 64'd1);
    step();
    check("ldstart valid drop", 64'(rvfi_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
